imm_gen_pipe: RTL and testbench

Parametrised, registered successor to the combinational immediate extender. It accepts a raw instruction word plus an immediate-format select and produces the XLEN-wide extended immediate one cycle later, through a valid/ready handshake with a 2-entry skid buffer. It adds XLEN=64 support, Z-type (CSR zimm) and shift-amount formats, a pass-through tag, flush, and optional illegal-format flagging. It sits between fetch/decode and the register-read stage.

---
 rtl/imm_gen_pipe.sv | 122 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate extender with a valid/ready handshake
// and a 2-entry skid buffer (entry A = output register, entry B = skid).
// Optional build macro IMM_ILLEGAL_FLAG_EN: carry a per-entry illegal flag
// for ctrl=111. Without it, illegal is tied low and no flag storage exists.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ctrl,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_FLAG_EN
        logic             ill;
`endif
    } ent_t;

    // Opcode bits never feed any format; named so lint treats them as intentionally unused.
    logic unused_opc;
    assign unused_opc = ^instr[6:0];

    // Build the 32-bit signed form first, then widen; sign extension to XLEN
    // falls out of the signed cast. Z and SHAMT are zero-extended instead.
    function automatic logic [XLEN-1:0] decode(input logic [31:0] i, input logic [2:0] c);
        logic signed [31:0] v;
        logic [XLEN-1:0]    r;
        v = '0;
        r = '0;
        case (c)
            3'b000: begin v = {{20{i[31]}}, i[31:20]};                                r = XLEN'(v); end
            3'b001: begin v = {{20{i[31]}}, i[31:25], i[11:7]};                       r = XLEN'(v); end
            3'b010: begin v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};    r = XLEN'(v); end
            3'b011: begin v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};  r = XLEN'(v); end
            3'b100: begin v = {i[31:12], 12'b0};                                      r = XLEN'(v); end
            3'b101: r = XLEN'(i[19:15]);
            3'b110: r = (XLEN == 64) ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
            default: r = '0;
        endcase
        return r;
    endfunction

    ent_t ent_a, ent_b, ent_in;
    logic a_full, b_full;
    logic acc, cons;

    assign in_ready  = !b_full;
    assign out_valid = a_full;
    assign acc       = in_valid && in_ready;
    assign cons      = out_valid && out_ready;

    // Decode the incoming word into a buffer entry.
    always_comb begin
        ent_in     = '0;
        ent_in.imm = decode(instr, ctrl);
        ent_in.tag = tag;
`ifdef IMM_ILLEGAL_FLAG_EN
        ent_in.ill = (ctrl == 3'b111);
`endif
    end

    // Skid-buffer occupancy and data movement; flush drops everything, including a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
            ent_a  <= '0;
            ent_b  <= '0;
        end else if (flush) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
        end else if (!a_full) begin
            if (acc) begin
                ent_a  <= ent_in;
                a_full <= 1'b1;
            end
        end else if (b_full) begin
            // in_ready is low here, so only a drain can happen.
            if (cons) begin
                ent_a  <= ent_b;
                b_full <= 1'b0;
            end
        end else if (acc) begin
            if (cons) begin
                ent_a <= ent_in;
            end else begin
                ent_b  <= ent_in;
                b_full <= 1'b1;
            end
        end else if (cons) begin
            a_full <= 1'b0;
        end
    end

    assign imm     = ent_a.imm;
    assign out_tag = ent_a.tag;
`ifdef IMM_ILLEGAL_FLAG_EN
    assign illegal = ent_a.ill;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance
// driven by the same stimulus; inputs change and outputs are sampled on negedge.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  ctrl;
    logic [4:0]  tag;

    logic        rdy32, ov32, il32;
    logic [31:0] imm32;
    logic [4:0]  ot32;
    logic        rdy64, ov64, il64;
    logic [63:0] imm64;
    logic [4:0]  ot64;

    int checks   = 0;
    int failures = 0;

`ifdef IMM_ILLEGAL_FLAG_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_d32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .ctrl(ctrl), .tag(tag), .out_valid(ov32), .out_ready(out_ready),
        .imm(imm32), .out_tag(ot32), .illegal(il32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_d64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .ctrl(ctrl), .tag(tag), .out_valid(ov64), .out_ready(out_ready),
        .imm(imm64), .out_tag(ot64), .illegal(il64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [2:0] c, input logic [31:0] i, input logic [4:0] t);
        in_valid = v;
        ctrl     = c;
        instr    = i;
        tag      = t;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drv(1'b0, 3'b000, 32'h0, 5'd0);
        #1;
        chk("rst_ov32", ov32, 0);
        chk("rst_rdy32", rdy32, 1);
        chk("rst_imm32", imm32, 0);
        chk("rst_tag32", ot32, 0);
        chk("rst_il32", il32, 0);
        chk("rst_ov64", ov64, 0);
        chk("rst_imm64", imm64, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // streaming with out_ready high: one result per cycle, in order
        @(negedge clk);
        out_ready = 1'b1;
        drv(1'b1, 3'b000, 32'hFFF00093, 5'd0);
        @(negedge clk);
        chk("i_ov", ov32, 1);
        chk("i_imm32", imm32, 32'hFFFFFFFF);
        chk("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        drv(1'b1, 3'b001, 32'hFE112E23, 5'd1);
        @(negedge clk);
        chk("s_imm32", imm32, 32'hFFFFFFFC);
        chk("s_tag", ot32, 1);
        drv(1'b1, 3'b011, 32'hFF9FF06F, 5'd2);
        @(negedge clk);
        chk("j_imm32", imm32, 32'hFFFFFFF8);
        chk("j_tag", ot32, 2);
        drv(1'b1, 3'b101, 32'h000F8073, 5'd3);
        @(negedge clk);
        chk("z_imm32", imm32, 32'h0000001F);
        chk("z_imm64", imm64, 64'h1F);
        chk("z_tag", ot32, 3);
        drv(1'b1, 3'b100, 32'h80000037, 5'd4);
        @(negedge clk);
        chk("u_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("u_imm32", imm32, 32'h80000000);
        drv(1'b1, 3'b110, 32'h03F00013, 5'd5);
        @(negedge clk);
        chk("sh_imm64", imm64, 64'h3F);
        chk("sh_imm32", imm32, 32'h1F);
        drv(1'b1, 3'b010, 32'hFE000EE3, 5'd6);
        @(negedge clk);
        chk("b_imm32", imm32, 32'hFFFFFFFC);
        chk("b_tag", ot32, 6);
        drv(1'b0, 3'b000, 32'h0, 5'd0);
        @(negedge clk);
        chk("drain_ov", ov32, 0);
        chk("drain_rdy", rdy32, 1);

        // stall: fill A then B, output must hold on the older entry
        out_ready = 1'b0;
        drv(1'b1, 3'b000, 32'h00500093, 5'd7);
        @(negedge clk);
        chk("st1_ov", ov32, 1);
        chk("st1_tag", ot32, 7);
        chk("st1_rdy", rdy32, 1);
        drv(1'b1, 3'b000, 32'h00800093, 5'd8);
        @(negedge clk);
        chk("st2_rdy", rdy32, 0);
        chk("st2_tag", ot32, 7);
        chk("st2_imm", imm32, 5);
        drv(1'b0, 3'b000, 32'h0, 5'd0);
        @(negedge clk);
        chk("st3_tag", ot32, 7);
        chk("st3_imm", imm32, 5);
        chk("st3_rdy64", rdy64, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("st4_tag", ot32, 8);
        chk("st4_imm", imm32, 8);
        chk("st4_rdy", rdy32, 1);
        @(negedge clk);
        chk("st5_ov", ov32, 0);

        // flush with both entries full and a same-cycle input
        out_ready = 1'b0;
        drv(1'b1, 3'b000, 32'h00900093, 5'd9);
        @(negedge clk);
        drv(1'b1, 3'b000, 32'h00A00093, 5'd10);
        @(negedge clk);
        chk("fl_full_rdy", rdy32, 0);
        flush = 1'b1;
        drv(1'b1, 3'b000, 32'h00B00093, 5'd11);
        @(negedge clk);
        chk("fl_ov", ov32, 0);
        chk("fl_rdy", rdy32, 1);
        flush = 1'b0;
        drv(1'b0, 3'b000, 32'h0, 5'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_empty_ov", ov32, 0);

        // async reset in the middle of a stall
        out_ready = 1'b0;
        drv(1'b1, 3'b000, 32'h00C00093, 5'd12);
        @(negedge clk);
        drv(1'b1, 3'b000, 32'h00D00093, 5'd13);
        @(negedge clk);
        drv(1'b0, 3'b000, 32'h0, 5'd0);
        chk("rs_pre_ov", ov32, 1);
        rst = 1'b1;
        #1;
        chk("rs_ov", ov32, 0);
        chk("rs_rdy", rdy32, 1);
        chk("rs_imm", imm32, 0);
        chk("rs_tag", ot32, 0);
        @(negedge clk);
        rst = 1'b0;

        // undefined format: imm=0, flag only when the feature is built
        out_ready = 1'b1;
        drv(1'b1, 3'b111, 32'hFFFFFFFF, 5'd14);
        @(negedge clk);
        chk("ill_imm32", imm32, 0);
        chk("ill_imm64", imm64, 0);
        chk("ill_flag32", il32, ILL_EXP);
        chk("ill_flag64", il64, ILL_EXP);
        chk("ill_tag", ot32, 14);
        drv(1'b1, 3'b000, 32'hFFF00093, 5'd15);
        @(negedge clk);
        chk("ill_next_flag", il32, 0);
        chk("ill_next_imm", imm32, 32'hFFFFFFFF);
        drv(1'b0, 3'b000, 32'h0, 5'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
